// File: rtl/uart_tx_frame_if.sv
// Handshake and serial-line bundle for uart_tx_frame.
// The master side supplies the word and its parity. The slave (transmitter) side drives the line
// and the status flags.
interface uart_tx_frame_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             par_bit;
  logic             TX_OUT;
  logic             busy;
  logic             frame_done;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, par_bit,
    input  TX_OUT, busy, frame_done
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, par_bit,
    output TX_OUT, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: one bit per CLK cycle, frame = start, WIDTH data bits (LSB first),
// optional parity, stop. Defining UART_TX_STOP2_EN appends a second stop bit.
// All outputs come straight from flops.
module uart_tx_frame #(
  parameter int unsigned WIDTH = 8
) (
  input logic             CLK,
  input logic             RST,
  uart_tx_frame_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

`ifdef UART_TX_STOP2_EN
  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StStop2
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop
  } state_e;
`endif

  state_e           state_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             par_en_q;

  assign bus.TX_OUT     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  // Frame sequencer; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!busy_q && bus.Data_Valid) begin
            data_q   <= bus.P_DATA;
            par_en_q <= bus.PAR_EN;
            state_q  <= StStart;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        StStart: begin
          // Shift register hands out the next bit at bit 0; the counter tracks position.
          tx_q    <= data_q[0];
          data_q  <= data_q >> 1;
          cnt_q   <= '0;
          state_q <= StData;
        end
        StData: begin
          if (cnt_q == LastBit) begin
            if (par_en_q) begin
              state_q <= StParity;
              tx_q    <= bus.par_bit;
            end else begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            tx_q   <= data_q[0];
            data_q <= data_q >> 1;
          end
        end
        StParity: begin
          state_q <= StStop;
          tx_q    <= 1'b1;
        end
        StStop: begin
`ifdef UART_TX_STOP2_EN
          state_q <= StStop2;
          tx_q    <= 1'b1;
`else
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`endif
        end
`ifdef UART_TX_STOP2_EN
        StStop2: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
`endif
        default: begin
          // Corrupted state: return to an idle line without reporting a frame.
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a table of frames plus hand-written sequences for held-valid,
// mid-frame reset and input churn. The expected line bits for every frame are built by a
// small model and placed in a scoreboard queue.
module tb_uart_tx_frame;

  localparam int unsigned W = 8;
`ifdef UART_TX_STOP2_EN
  localparam int NStop = 2;
`else
  localparam int NStop = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic sb[$];

  uart_tx_frame_if #(.WIDTH(W)) bus ();

  uart_tx_frame #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pb;
    bit         mutate;
    int         exp_len;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected line contents of one frame.
  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pb);
    sb.push_back(1'b0);
    for (int i = 0; i < int'(W); i++) sb.push_back(d[i]);
    if (pe) sb.push_back(pb);
    for (int i = 0; i < NStop; i++) sb.push_back(1'b1);
  endfunction

  // Called at the negedge before the accepting edge. Compares each frame cycle against the
  // scoreboard, then checks the first idle cycle with its frame_done pulse.
  task automatic check_frame(input string name, input int exp_len, input bit release_dv,
                             input bit mutate, input logic [7:0] data_after);
    int n;
    int busy_cycles;
    logic exp_bit;
    n = sb.size();
    busy_cycles = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp_bit = sb.pop_front();
      chk($sformatf("%s tx[%0d]", name, i), bus.TX_OUT, exp_bit);
      chk($sformatf("%s done_low[%0d]", name, i), bus.frame_done, 1'b0);
      if (bus.busy === 1'b1) busy_cycles++;
      if (i == 0) begin
        if (release_dv) bus.Data_Valid = 1'b0;
        bus.P_DATA = data_after;
      end
      if (mutate) begin
        bus.P_DATA = 8'($urandom);
        bus.PAR_EN = 1'($urandom);
        if (i == 0 || release_dv) bus.Data_Valid = 1'($urandom);
      end
    end
    if (mutate) bus.Data_Valid = 1'b0;
    chk_int({name, " busy_len"}, busy_cycles, exp_len);
    @(negedge clk);
    chk({name, " idle_tx"}, bus.TX_OUT, 1'b1);
    chk({name, " idle_busy"}, bus.busy, 1'b0);
    chk({name, " done_pulse"}, bus.frame_done, 1'b1);
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    chk({name, " q_tx"}, bus.TX_OUT, 1'b1);
    chk({name, " q_busy"}, bus.busy, 1'b0);
    chk({name, " q_done"}, bus.frame_done, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{data: 8'hA5, pe: 1'b1, pb: 1'b0, mutate: 1'b0, exp_len: 11 + NStop - 1};
    vecs[1] = '{data: 8'h01, pe: 1'b0, pb: 1'b1, mutate: 1'b0, exp_len: 10 + NStop - 1};
    vecs[2] = '{data: 8'hFF, pe: 1'b0, pb: 1'b0, mutate: 1'b0, exp_len: 10 + NStop - 1};
    vecs[3] = '{data: 8'h07, pe: 1'b1, pb: 1'b1, mutate: 1'b0, exp_len: 11 + NStop - 1};
    vecs[4] = '{data: 8'h3C, pe: 1'b1, pb: 1'b0, mutate: 1'b1, exp_len: 11 + NStop - 1};
    vecs[5] = '{data: 8'h80, pe: 1'b0, pb: 1'b1, mutate: 1'b1, exp_len: 10 + NStop - 1};

    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.par_bit    = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset tx", bus.TX_OUT, 1'b1);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.frame_done, 1'b0);
    rst_n = 1'b1;
    check_quiet("post_reset0");
    check_quiet("post_reset1");

    // Table of single frames.
    for (int v = 0; v < 6; v++) begin
      push_frame(vecs[v].data, vecs[v].pe, vecs[v].pb);
      bus.P_DATA     = vecs[v].data;
      bus.PAR_EN     = vecs[v].pe;
      bus.par_bit    = vecs[v].pb;
      bus.Data_Valid = 1'b1;
      check_frame($sformatf("vec%0d", v), vecs[v].exp_len, 1'b1, vecs[v].mutate, vecs[v].data);
      bus.PAR_EN = 1'b0;
      check_quiet($sformatf("vec%0d", v));
    end

    // Data_Valid held high: 0x55 then 0xAA with one idle cycle between frames.
    push_frame(8'h55, 1'b1, 1'b0);
    bus.P_DATA     = 8'h55;
    bus.PAR_EN     = 1'b1;
    bus.par_bit    = 1'b0;
    bus.Data_Valid = 1'b1;
    check_frame("held0", 10 + NStop, 1'b0, 1'b0, 8'hAA);
    push_frame(8'hAA, 1'b1, 1'b0);
    check_frame("held1", 10 + NStop, 1'b1, 1'b0, 8'hAA);
    bus.PAR_EN = 1'b0;
    check_quiet("held");

    // Reset during data bit 3 takes effect with no clock edge.
    bus.P_DATA     = 8'hC3;
    bus.PAR_EN     = 1'b1;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    chk("rst_mid start", bus.TX_OUT, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_mid bit3", bus.TX_OUT, 1'b0);
    chk("rst_mid busy_before", bus.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid tx", bus.TX_OUT, 1'b1);
    chk("rst_mid busy", bus.busy, 1'b0);
    chk("rst_mid done", bus.frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("rst_mid");
    sb.delete();
    push_frame(8'h96, 1'b1, 1'b0);
    bus.P_DATA     = 8'h96;
    bus.PAR_EN     = 1'b1;
    bus.par_bit    = 1'b0;
    bus.Data_Valid = 1'b1;
    check_frame("after_rst", 10 + NStop, 1'b1, 1'b0, 8'h96);
    check_quiet("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per frame (WIDTH >= 2).
REQ-002 SHALL have port CLK  input  1  bit-rate clock (one serial bit per CLK cycle).
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  WIDTH  parallel data word to transmit.
REQ-005 SHALL have port Data_Valid  input  1  request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  parity bit inserted when 1.
REQ-007 SHALL have port par_bit  input  1  registered parity of the accepted word, from the upstream parity calculator.
REQ-008 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress; also gates upstream parity-data capture.
REQ-010 SHALL have port frame_done  output  1  single-cycle pulse after the last stop bit.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, and STOP2 (STOP2 only per REQ-026); all outputs registered.
REQ-012 SHALL accept a word at a rising CLK edge only when state==IDLE && busy==0 && Data_Valid==1.
REQ-013 On acceptance SHALL latch P_DATA and PAR_EN internally, go to START, and drive TX_OUT<=0 and busy<=1 at that edge.
REQ-014 SHALL ignore Data_Valid, P_DATA and PAR_EN while busy==1; changes mid-frame SHALL NOT alter the frame.
REQ-015 START SHALL last 1 cycle, then enter DATA.
REQ-016 DATA SHALL last WIDTH cycles, sending bits LSB first, indexed by a bit counter of width $clog2(WIDTH) that resets to 0 on entering DATA.
REQ-017 After bit WIDTH-1, SHALL go to PARITY if latched PAR_EN==1, else to STOP.
REQ-018 PARITY SHALL drive TX_OUT=par_bit, sampled at the edge entering PARITY, and hold it for 1 cycle.
REQ-019 STOP SHALL drive TX_OUT=1 for 1 cycle.
REQ-020 On leaving the final stop state SHALL go to IDLE with busy<=0, TX_OUT<=1, and frame_done<=1 for exactly one cycle.
REQ-021 SHALL produce a frame of 1+WIDTH+PAR_EN+1 cycles, or 1+WIDTH+PAR_EN+2 cycles with STOP2.
REQ-022 Back-to-back requests SHALL see at least one IDLE cycle with busy==0 between frames; Data_Valid held high SHALL be accepted in the first such cycle.
REQ-023 Illegal state encodings SHALL recover to IDLE on the next edge with TX_OUT=1 and busy=0.

Reset
REQ-024 RST low SHALL immediately force state=IDLE, TX_OUT=1, busy=0, frame_done=0, bit counter=0 and latched data=0, including mid-frame.
REQ-025 After RST release, SHALL accept no word before the first rising CLK edge at which REQ-012 holds.

Configuration
REQ-026 SHALL use macro UART_TX_STOP2_EN: when defined, STOP is followed by STOP2 (TX_OUT=1, 1 cycle) before IDLE; when undefined, STOP2 is absent and STOP goes directly to IDLE.

Verification
REQ-027 Reset, then P_DATA=0xA5, PAR_EN=1, par_bit=0 -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,0,1; busy high for 11 cycles; one frame_done pulse.
REQ-028 P_DATA=0x01, PAR_EN=0 -> TX_OUT 0,1,0,0,0,0,0,0,0,1 (10 cycles); no parity cycle.
REQ-029 Data_Valid held high with 0x55 then 0xAA, PAR_EN=1 -> two complete frames with exactly one idle cycle (TX_OUT=1, busy=0) between them.
REQ-030 RST asserted during DATA bit 3 -> TX_OUT=1 and busy=0 immediately with no clock edge; the next request yields a full, correct frame.
REQ-031 PAR_EN and P_DATA toggled while busy=1 -> the frame in flight is unchanged.
REQ-032 With UART_TX_STOP2_EN defined, 0xFF, PAR_EN=0 -> 11-cycle frame ending in two stop bits of 1, then frame_done.
